csd_shift_add_mult: RTL and testbench

Downstream consumer of the CSD conversion stage. It reads one canonical-signed-digit coefficient (a positive/negative digit-mask pair) from the CSD store and multiplies a signed operand by it. Each non-zero digit produces one shift-add or shift-subtract, giving a sequential, multiplier-free product. It also flags coefficients that break the CSD rules: overlapping or adjacent non-zero digits.

---
 rtl/csd_pkg.sv | 31 +++
 rtl/csd_digit_check.sv | 28 ++
 rtl/csd_shift_add_mult.sv | 147 ++++++++++++++
 tb/tb_csd_shift_add_mult.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/csd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csd_pkg
// Description : Shared types and constants for the CSD shift-add multiplier
//               and its digit-rule checker.
// Revision    : 1.0 - initial release
// ============================================================================
package csd_pkg;

  // Default geometry: 8 CSD digits per coefficient and 8-bit operands.
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_RES_W  = 2 * DEF_DATA_W + 1;

  // A coefficient occupies two words. The P mask is at the even address and
  // the N mask is at the odd address.
  localparam logic P_OFS = 1'b0;
  localparam logic N_OFS = 1'b1;

  // Multiplier sequencing states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_P  = 3'd1,
    S_RD_N  = 3'd2,
    S_CAP_N = 3'd3,
    S_CALC  = 3'd4,
    S_DONE  = 3'd5
  } csd_state_t;

endpackage : csd_pkg
`default_nettype wire

// File: rtl/csd_digit_check.sv
`default_nettype none
// ============================================================================
// Module      : csd_digit_check
// Description : Combinational CSD rule check. The flag rises when a digit
//               position is both +1 and -1, or when two neighbouring digits
//               are both non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module csd_digit_check
  import csd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] p_mask,
  input  logic [DATA_W-1:0] n_mask,
  output logic              invalid
);

  logic [DATA_W-1:0] nonzero;

  // The invalid flag covers both overlapping digits and adjacent non-zero digits.
  always_comb begin
    nonzero = p_mask | n_mask;
    invalid = (|(p_mask & n_mask)) | (|(nonzero & (nonzero >> 1)));
  end

endmodule : csd_digit_check
`default_nettype wire

// File: rtl/csd_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : csd_shift_add_mult
// Description : Sequential multiplier-free product of a signed operand and a
//               CSD coefficient that is fetched as a P/N mask pair from the
//               CSD store. Each digit position costs one cycle. An invalid
//               coefficient is still multiplied and is also flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module csd_shift_add_mult
  import csd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RES_W  = 2 * DATA_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-2:0] coeffIdx,
  input  logic [DATA_W-1:0] xIn,
  output logic              csdRe,
  output logic [ADDR_W-1:0] csdAddr,
  input  logic [DATA_W-1:0] csdData,
  output logic [RES_W-1:0]  result,
  output logic              errCsd,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);

  csd_state_t        state;
  csd_state_t        state_next;
  logic [DATA_W-1:0] x_reg;
  logic [ADDR_W-2:0] idx_reg;
  logic [DATA_W-1:0] p_reg;
  logic [DATA_W-1:0] n_reg;
  logic [RES_W-1:0]  acc;
  logic [RES_W-1:0]  acc_next;
  logic [RES_W-1:0]  term;
  logic [CNT_W-1:0]  cnt;
  logic              last_digit;
  logic              err_pend;
  logic              err_now;

  // The P mask is already registered when the N word arrives on csdData.
  csd_digit_check #(
    .DATA_W (DATA_W)
  ) u_digit_check (
    .p_mask  (p_reg),
    .n_mask  (csdData),
    .invalid (err_now)
  );

  // Shift-add step for the current digit. When both P and N are set, the
  // add and the subtract cancel out.
  always_comb begin
    term       = {{(RES_W-DATA_W){x_reg[DATA_W-1]}}, x_reg} << cnt;
    acc_next   = acc;
    if (p_reg[cnt]) acc_next = acc_next + term;
    if (n_reg[cnt]) acc_next = acc_next - term;
    last_digit = (cnt == CNT_W'(DATA_W - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic and the state-decoded outputs.
  always_comb begin
    state_next = state;
    csdRe      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_RD_P;
      end
      S_RD_P: begin
        csdRe      = 1'b1;
        state_next = S_RD_N;
      end
      S_RD_N: begin
        csdRe      = 1'b1;
        state_next = S_CAP_N;
      end
      S_CAP_N: state_next = S_CALC;
      S_CALC:  if (last_digit) state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath. The store address leads the state by one edge so that it is
  // valid throughout RD_P and RD_N. result and errCsd load on the edge that
  // enters DONE, so they are valid while done is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_reg    <= '0;
      idx_reg  <= '0;
      p_reg    <= '0;
      n_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
      csdAddr  <= '0;
      result   <= '0;
      errCsd   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_reg   <= xIn;
            idx_reg <= coeffIdx;
            acc     <= '0;
            csdAddr <= {coeffIdx, P_OFS};
          end
        end
        S_RD_P:  csdAddr <= {idx_reg, N_OFS};
        S_RD_N:  p_reg <= csdData;
        S_CAP_N: begin
          n_reg    <= csdData;
          err_pend <= err_now;
          cnt      <= '0;
        end
        S_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last_digit) begin
            result <= acc_next;
            errCsd <= err_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : csd_shift_add_mult
`default_nettype wire

// File: tb/tb_csd_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_csd_shift_add_mult
// Description : Directed self-checking bench for csd_shift_add_mult. It
//               includes a one-cycle-latency CSD store model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csd_shift_add_mult;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  coeffIdx;
  logic [7:0]  xIn;
  logic        csdRe;
  logic [3:0]  csdAddr;
  logic [7:0]  csdData;
  logic [16:0] result;
  logic        errCsd;
  logic        busy;
  logic        done;

  logic [7:0]  mem [16];
  logic [7:0]  rd_q;
  int          total;
  int          bad;
  int          cyc;
  int          dones;

  csd_shift_add_mult dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .coeffIdx (coeffIdx),
    .xIn      (xIn),
    .csdRe    (csdRe),
    .csdAddr  (csdAddr),
    .csdData  (csdData),
    .result   (result),
    .errCsd   (errCsd),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSD store model: read data appears in the cycle after csdRe.
  always @(posedge clk) if (csdRe) rd_q <= mem[csdAddr];
  assign csdData = rd_q;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one multiplication. Afterwards it checks the store addressing,
  // the done latency, the busy span, result and errCsd.
  task automatic run_op(input string tag, input logic [2:0] idx,
                        input logic [7:0] x, input int exp_res,
                        input logic exp_err);
    int c;
    int busy_cnt;
    bit seen;
    @(posedge clk); #1;
    coeffIdx = idx; xIn = x; start = 1'b1;
    @(posedge clk); #1;                       // cycle 1
    start = 1'b0; coeffIdx = 3'd7; xIn = 8'h3C; // later input changes must not matter
    chk({tag, "_re_p"}, csdRe, 1);
    chk({tag, "_addr_p"}, csdAddr, {idx, 1'b0});
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    @(posedge clk); #1;                       // cycle 2
    chk({tag, "_addr_n"}, csdAddr, {idx, 1'b1});
    if (busy === 1'b1) busy_cnt++;
    c = 2; seen = 0;
    while (c < 30 && !seen) begin
      @(posedge clk); #1; c++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) seen = 1;
    end
    chk({tag, "_latency"}, c, 12);
    chk({tag, "_busy_cycles"}, busy_cnt, 12);
    chk({tag, "_result"}, $signed(result), exp_res);
    chk({tag, "_err"}, errCsd, exp_err);
    chk({tag, "_re_idle"}, csdRe, 0);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_busy_drop"}, busy, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0]  = 8'h04; mem[1]  = 8'h01;   // 4-1 = 3
    mem[2]  = 8'hAA; mem[3]  = 8'h00;   // 170
    mem[4]  = 8'h00; mem[5]  = 8'h01;   // -1
    mem[6]  = 8'h03; mem[7]  = 8'h00;   // 3, adjacent digits
    mem[8]  = 8'h01; mem[9]  = 8'h01;   // 0, overlapping digits
    mem[10] = 8'h50; mem[11] = 8'h05;   // 80-5 = 75
    rd_q = 8'h00;
    reset = 1'b0; start = 1'b0; coeffIdx = 3'd0; xIn = 8'h00;

    // Reset state
    #12;
    chk("rst_result", result, 0);
    chk("rst_err", errCsd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re", csdRe, 0);
    chk("rst_addr", csdAddr, 0);
    @(posedge clk); #1; reset = 1'b1;

    // Main function
    run_op("op3x5",      3'd0, 8'h05, 15,     1'b0);
    run_op("op170xm128", 3'd1, 8'h80, -21760, 1'b0);
    run_op("opm1xm128",  3'd2, 8'h80, 128,    1'b0);
    run_op("opm1x0",     3'd2, 8'h00, 0,      1'b0);
    run_op("adjacent",   3'd3, 8'h02, 6,      1'b1);
    run_op("overlap",    3'd4, 8'h02, 0,      1'b1);

    // Start pulses in cycle 3 and in the DONE cycle are ignored
    @(posedge clk); #1;
    coeffIdx = 3'd0; xIn = 8'h05; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; coeffIdx = 3'd1; xIn = 8'h64;
    cyc = 1; dones = 0;
    while (cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (done === 1'b1) dones++;
      start = (cyc == 3 || cyc == 12) ? 1'b1 : 1'b0;
    end
    chk("extra_start_dones", dones, 1);
    chk("extra_start_result", $signed(result), 15);
    chk("extra_start_idle", busy, 0);

    // Reset during CALC
    @(posedge clk); #1;
    coeffIdx = 3'd5; xIn = 8'hF9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1;                                       // cycle 6, CALC
    chk("mid_busy", busy, 1);
    reset = 1'b0; #1;
    chk("abort_result", result, 0);
    chk("abort_err", errCsd, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_re", csdRe, 0);
    chk("abort_addr", csdAddr, 0);
    dones = 0;
    repeat (3) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
    reset = 1'b1;
    repeat (14) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
    chk("abort_no_done", dones, 0);
    run_op("after_rst",  3'd5, 8'hF9, -525,   1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_csd_shift_add_mult
`default_nettype wire
